alu32_seq_ctrl: RTL and testbench
=================================

Name: alu32_seq_ctrl

Overview:
- Issue/sequencing controller in front of alu32.
- Accepts one operation at a time over a valid/ready request port and drives alu32 operands, aluop and the multiplier start (alu_rst).
- Waits the fixed latency of the selected op: multiply is sequential and multi-cycle; all other ops are combinational.
- Returns the captured result over a valid/ready response port. This lets upstream logic use alu32 without knowing multiplier timing.

Parameters:
- MUL_CYCLES, 64: clock edges after multiplier start until alu32 result is valid; must be ≥1.
- COMB_CYCLES, 1: settle edges for non-multiply ops; must be ≥1.
- MUL_OP, 3'b010: aluop encoding that selects the sequential multiplier.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_a  in  32  operand a (signed).
- req_b  in  32  operand b (signed).
- req_op  in  3  aluop.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_result  out  32  captured alu32 result.
- alu_a  out  32  to alu32 a.
- alu_b  out  32  to alu32 b.
- alu_op  out  3  to alu32 aluop.
- alu_rst  out  1  to alu32 rst (multiplier start/clear).
- alu_result  in  32  from alu32 result.
- busy  out  1  high in any state other than IDLE.

Interface: one clock; reset is synchronous and active-high (clk, rst).

Behaviour:
- Reset values: state IDLE, rsp_valid 0, rsp_result 0, alu_a/alu_b 0, alu_op 3'b000, counter 0. alu_rst = rst OR (state==MSTART), so it is 1 while rst is high. req_ready and busy are 0 while rst is high.
- req_ready = (state==IDLE) AND NOT rst. A request is accepted on the edge where req_valid && req_ready. req_a/req_b/req_op are registered into alu_a/alu_b/alu_op and held stable until the next acceptance.
- FSM states: IDLE, EXEC, MSTART, MWAIT, RESP.
- IDLE: on accept, go to MSTART if req_op==MUL_OP, else go to EXEC with counter=COMB_CYCLES-1.
- EXEC: if counter==0, capture alu_result into rsp_result and go to RESP; else decrement.
- MSTART: exactly one cycle with alu_rst=1; go to MWAIT with counter=MUL_CYCLES-1.
- MWAIT: if counter==0, capture alu_result and go to RESP; else decrement.
- RESP: rsp_valid=1 and rsp_result held stable until rsp_ready. On handshake go to IDLE; rsp_valid=0 next cycle.
- Latency, counted from the accept edge E0:
  - non-mul: rsp_valid high after COMB_CYCLES edges;
  - mul: rsp_valid high after MUL_CYCLES+1 edges.
- No back-to-back issue: at least one IDLE cycle between the response handshake and the next accept.
- Requests arriving while not ready are ignored; upstream must hold them, standard valid/ready.
- rsp_ready while rsp_valid=0 has no effect.
- Reset mid-operation (any state) returns to IDLE on that edge. The in-flight op is discarded and no response is produced.
- rsp_valid only rises in RESP, so a result is never presented before the latency expires.

Optional Feature:
- Macro ALU32_SEQ_STATS_EN.
- When defined, adds two outputs:
  - stat_ops (32): increments on every response handshake;
  - stat_mul_ops (32): increments on handshakes of MUL_OP ops.
- Both counters clear on rst and wrap modulo 2^32.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared include alu32_seq_defs.vh holds:
  - FSM state localparams (IDLE..RESP, 3-bit);
  - the aluop encoding constants, including the MUL_OP default 3'b010.
- One natural sub-module: alu32_seq_lat_cnt, a loadable down-counter with load value, enable and zero flag, sized by clog2 of max(MUL_CYCLES, COMB_CYCLES).

Test Plan (bench uses alu32 with MUL_CYCLES matched to its multiplier):
- After rst high 2 cycles then low: req_ready=1, rsp_valid=0, alu_rst=0 on the first post-reset cycle.
- a=12, b=8, op=010 accepted, rsp_ready=1 → alu_rst high exactly 1 cycle; rsp_valid rises MUL_CYCLES+1 edges after accept with rsp_result=96; req_ready=0 throughout.
- a=-7, b=6, op=010 → rsp_result=-42 (32'hFFFFFFD6).
- op=000, a=12, b=8 → rsp_valid after COMB_CYCLES edges; rsp_result equals alu32's op-000 output for 12,8; alu_rst stays 0.
- Response held: rsp_ready=0 for 5 cycles after rsp_valid → rsp_valid and rsp_result stable, req_ready=0, new req_valid ignored; raise rsp_ready → IDLE next cycle.
- Reset asserted in MWAIT at counter=10 → IDLE next edge, rsp_valid never asserts for that op. The next mul (3×4) returns 12. With ALU32_SEQ_STATS_EN, stat_ops=1 and stat_mul_ops=1 after that single handshake.

Source files
------------

// File: rtl/alu32_seq_ctrl_pkg.sv
// rtl/alu32_seq_ctrl_pkg.sv - shared FSM states, aluop constants and counter sizing for alu32_seq_ctrl
package alu32_seq_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_EXEC   = 3'd1;
  localparam logic [2:0] ST_MSTART = 3'd2;
  localparam logic [2:0] ST_MWAIT  = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b010;

  // The counter only ever holds latency-1, so clog2 of the larger latency suffices.
  function automatic int lat_cnt_width(input int mul_cycles, input int comb_cycles);
    int mx;
    mx = (mul_cycles > comb_cycles) ? mul_cycles : comb_cycles;
    return (mx < 2) ? 1 : $clog2(mx);
  endfunction

endpackage

// File: rtl/alu32_seq_lat_cnt.sv
// rtl/alu32_seq_lat_cnt.sv - loadable down-counter with zero flag used to time alu32 latency
module alu32_seq_lat_cnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/alu32_seq_ctrl.sv
// rtl/alu32_seq_ctrl.sv - valid/ready issue controller hiding alu32 multiplier latency
// Optional statistics counters are enabled by defining ALU32_SEQ_STATS_EN.
module alu32_seq_ctrl
  import alu32_seq_ctrl_pkg::*;
#(
  parameter int         MUL_CYCLES  = 64,
  parameter int         COMB_CYCLES = 1,
  parameter logic [2:0] MUL_OP      = OP_MUL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [2:0]  req_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_rst,
  input  logic [31:0] alu_result,
  output logic        busy
`ifdef ALU32_SEQ_STATS_EN
  ,
  output logic [31:0] stat_ops,
  output logic [31:0] stat_mul_ops
`endif
);

  localparam int            CW        = lat_cnt_width(MUL_CYCLES, COMB_CYCLES);
  localparam logic [CW-1:0] MUL_LOAD  = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] COMB_LOAD = CW'(COMB_CYCLES - 1);

  logic [2:0]    state;
  logic          accept;
  logic          cnt_load;
  logic          cnt_en;
  logic          cnt_zero;
  logic [CW-1:0] cnt_val;

  assign req_ready = (state == ST_IDLE) && !rst;
  assign busy      = (state != ST_IDLE) && !rst;
  assign alu_rst   = rst || (state == ST_MSTART);
  assign accept    = req_valid && req_ready;

  // Multiply loads its count on leaving MSTART so the start cycle is not counted twice.
  always_comb begin
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = COMB_LOAD;
    case (state)
      ST_IDLE:   cnt_load = accept && (req_op != MUL_OP);
      ST_MSTART: begin
        cnt_load = 1'b1;
        cnt_val  = MUL_LOAD;
      end
      ST_EXEC, ST_MWAIT: cnt_en = 1'b1;
      default: ;
    endcase
  end

  alu32_seq_lat_cnt #(.W(CW)) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= OP_ADD;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_a  <= req_a;
            alu_b  <= req_b;
            alu_op <= req_op;
            state  <= (req_op == MUL_OP) ? ST_MSTART : ST_EXEC;
          end
        end
        ST_EXEC, ST_MWAIT: begin
          if (cnt_zero) begin
            rsp_result <= alu_result;
            rsp_valid  <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_MSTART: state <= ST_MWAIT;
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU32_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops     <= '0;
      stat_mul_ops <= '0;
    end else if ((state == ST_RESP) && rsp_ready) begin
      stat_ops <= stat_ops + 32'd1;
      if (alu_op == MUL_OP) begin
        stat_mul_ops <= stat_mul_ops + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu32_seq_ctrl.sv
// tb/tb_alu32_seq_ctrl.sv - scoreboard bench for alu32_seq_ctrl with a behavioural alu32 stand-in
module tb_alu32_seq_ctrl;

  localparam int MUL_CYCLES  = 16;
  localparam int COMB_CYCLES = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic        alu_rst;
  logic [31:0] alu_result;
  logic        busy;
`ifdef ALU32_SEQ_STATS_EN
  logic [31:0] stat_ops;
  logic [31:0] stat_mul_ops;
`endif

  alu32_seq_ctrl #(.MUL_CYCLES(MUL_CYCLES), .COMB_CYCLES(COMB_CYCLES), .MUL_OP(3'b010)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_rst    (alu_rst),
    .alu_result (alu_result),
    .busy       (busy)
`ifdef ALU32_SEQ_STATS_EN
    ,
    .stat_ops     (stat_ops),
    .stat_mul_ops (stat_mul_ops)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a * b;
      3'b011:  return a & b;
      3'b100:  return a | b;
      3'b101:  return a ^ b;
      3'b110:  return {31'b0, ($signed(a) < $signed(b))};
      default: return a << b[4:0];
    endcase
  endfunction

  // alu32 stand-in: the product only becomes visible MUL_CYCLES-1 edges after the start edge.
  logic [7:0] mcnt;
  always @(posedge clk) begin
    if (alu_rst) mcnt <= 8'd0;
    else if (mcnt != 8'hFF) mcnt <= mcnt + 8'd1;
  end
  always_comb begin
    alu_result = ref_alu(alu_op, alu_a, alu_b);
    if ((alu_op == 3'b010) && (mcnt < 8'(MUL_CYCLES - 1))) alu_result = 32'hDEADBEEF;
  end

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          pulses;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_acc = 0;
  int   n_hs  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples pre-edge handshakes, then inspects outputs 3 time units after the edge.
  int          cyc = 0;
  int          acc_cyc = 0;
  int          pulses = 0;
  int          rdy_hi = 0;
  bit          inflight = 0;
  bit          seen = 0;
  logic [31:0] held;
  always @(posedge clk) begin
    bit   s_acc, s_hs, s_rst;
    exp_t e;
    s_acc = req_valid && req_ready;
    s_hs  = rsp_valid && rsp_ready;
    s_rst = rst;
    #3;
    cyc++;
    if (s_rst) begin
      inflight = 0;
      seen     = 0;
    end else begin
      if (s_hs) begin
        n_hs++;
        inflight = 0;
        seen     = 0;
        check("rsp_drop", 32'(rsp_valid), 32'd0);
        check("idle_after_rsp", 32'(req_ready), 32'd1);
      end
      if (s_acc) begin
        n_acc++;
        inflight = 1;
        acc_cyc  = cyc;
        pulses   = 0;
        rdy_hi   = 0;
      end
      if (inflight && !seen) begin
        if (alu_rst) pulses++;
        if (req_ready) rdy_hi++;
      end
      if (rsp_valid && !seen) begin
        if (sbq.size() == 0) begin
          check("spurious_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = sbq.pop_front();
          check("result", rsp_result, e.res);
          check("latency", 32'(cyc - acc_cyc), 32'(e.lat));
          check("alu_rst_pulses", 32'(pulses), 32'(e.pulses));
          check("ready_while_busy", 32'(rdy_hi), 32'd0);
          seen = 1;
          held = rsp_result;
        end
      end else if (rsp_valid && seen) begin
        check("rsp_hold", rsp_result, held);
        check("ready_in_resp", 32'(req_ready), 32'd0);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input int hold);
    exp_t e;
    int   na, nh, t;
    e.res    = ref_alu(op, a, b);
    e.lat    = (op == 3'b010) ? MUL_CYCLES + 1 : COMB_CYCLES;
    e.pulses = (op == 3'b010) ? 1 : 0;
    sbq.push_back(e);
    na = n_acc;
    nh = n_hs;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    for (t = 0; t < 50 && n_acc == na; t++) @(negedge clk);
    check("accept", 32'(n_acc), 32'(na + 1));
    req_valid = 1'b0;
    if (hold > 0) begin
      for (t = 0; t < 200 && !rsp_valid; t++) @(negedge clk);
      repeat (hold) begin
        req_valid = 1'b1;
        req_a     = $urandom;
        req_b     = $urandom;
        req_op    = 3'($urandom_range(0, 7));
        @(negedge clk);
      end
      check("req_ignored_in_resp", 32'(n_acc), 32'(na + 1));
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    for (t = 0; t < 200 && n_hs == nh; t++) @(negedge clk);
    check("handshake", 32'(n_hs), 32'(nh + 1));
    rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int na;
    logic [2:0] op;
    rst       = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    @(negedge clk);
    check("alu_rst_in_reset", 32'(alu_rst), 32'd1);
    check("ready_in_reset", 32'(req_ready), 32'd0);
    check("busy_in_reset", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 32'd1);
    check("rsp_valid_after_reset", 32'(rsp_valid), 32'd0);
    check("alu_rst_after_reset", 32'(alu_rst), 32'd0);
    check("rsp_result_after_reset", rsp_result, 32'd0);
    check("alu_op_after_reset", 32'(alu_op), 32'd0);

    issue(32'd12, 32'd8, 3'b010, 0);
    issue(-32'sd7, 32'd6, 3'b010, 0);
    issue(32'd12, 32'd8, 3'b000, 0);
    issue(32'd12, 32'd8, 3'b000, 5);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 3'b010, 2);

    for (int i = 0; i < 20; i++) begin
      op = 3'($urandom_range(0, 7));
      issue($urandom, $urandom, op, $urandom_range(0, 3));
    end

    // Abort a multiply in MWAIT with the counter at 10; nothing is queued so any response is spurious.
    na        = n_acc;
    req_a     = 32'd5;
    req_b     = 32'd7;
    req_op    = 3'b010;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    for (int t = 0; t < 50 && n_acc == na; t++) @(negedge clk);
    check("abort_accept", 32'(n_acc), 32'(na + 1));
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_before_abort", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_abort", 32'(busy), 32'd0);
    check("ready_after_abort", 32'(req_ready), 32'd1);
    repeat (MUL_CYCLES + 4) @(negedge clk);
    rsp_ready = 1'b0;

    issue(32'd3, 32'd4, 3'b010, 0);
`ifdef ALU32_SEQ_STATS_EN
    check("stat_ops", stat_ops, 32'd1);
    check("stat_mul_ops", stat_mul_ops, 32'd1);
`endif
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
